stream_mux_rr: RTL and testbench

- Parametrised successor to the team's 32-bit 2:1 select mux.
- Merges NUM_IN valid/ready streams of WIDTH bits onto one output stream, with a registered output stage.
- Arbitrates per packet: round-robin by default, or forced to a fixed channel via a force select.
- Sits between parallel producers (ALU/datapath lanes, packet sources) and a single downstream consumer.

---
 rtl/stream_mux_rr.sv | 169 ++++++++++++++++
 tb/tb_stream_mux_rr.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: merges NUM_IN valid/ready streams onto one registered
// output stream. Arbitration happens per packet: round-robin by default,
// or a forced channel when force_en is set. Once a multi-beat packet
// starts, the channel stays locked until its last beat is accepted.
module stream_mux_rr #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_next_ptr;
  logic [SEL_W-1:0] r_lock;
  logic [SEL_W-1:0] w_next_lock;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic [SEL_W-1:0] r_out_src;

  logic             w_can_load;
  logic [SEL_W-1:0] w_rr_grant;
  logic             w_rr_valid;
  logic [SEL_W-1:0] w_grant;
  logic             w_grant_valid;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_last;

  assign w_can_load = !r_out_valid || out_ready;
  assign w_accept   = w_grant_valid && w_can_load;

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_src   = r_out_src;

  // Round-robin search: lowest valid channel above the pointer wins, else
  // the lowest valid channel at or below it (this is the circular wrap).
  always_comb begin
    w_rr_grant = '0;
    w_rr_valid = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_valid[i] && (SEL_W'(i) <= r_ptr)) begin
        w_rr_grant = SEL_W'(i);
        w_rr_valid = 1'b1;
      end
    end
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_valid[i] && (SEL_W'(i) > r_ptr)) begin
        w_rr_grant = SEL_W'(i);
        w_rr_valid = 1'b1;
      end
    end
  end

  // Pick the granted channel index for the current state; an index with no
  // matching valid channel (e.g. an out-of-range force) yields no grant.
  always_comb begin
    if (r_state == LOCK) begin
      w_grant = r_lock;
    end else if (force_en) begin
      w_grant = force_sel;
    end else begin
      w_grant = w_rr_grant;
    end
  end

  // Route the granted channel's beat and valid through a one-hot match.
  always_comb begin
    w_sel_data    = '0;
    w_sel_last    = 1'b0;
    w_grant_valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_sel_data    = in_data[i*WIDTH +: WIDTH];
        w_sel_last    = in_last[i];
        w_grant_valid = in_valid[i];
      end
    end
  end

  // Only the granted channel sees ready, and only when the output can load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = w_can_load && w_grant_valid && (w_grant == SEL_W'(i));
    end
  end

  // Packet-lock FSM next state: open a lock on a non-last beat, release the
  // lock and advance the round-robin pointer on a last beat.
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    w_next_lock  = r_lock;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_sel_last) begin
            w_next_ptr = w_grant;
          end else begin
            w_next_state = LOCK;
            w_next_lock  = w_grant;
          end
        end
      end
      LOCK: begin
        if (w_accept && w_sel_last) begin
          w_next_state = IDLE;
          w_next_ptr   = r_lock;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM, pointer and lock registers; pointer resets so channel 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= SEL_W'(NUM_IN - 1);
      r_lock  <= '0;
    end else begin
      r_state <= w_next_state;
      r_ptr   <= w_next_ptr;
      r_lock  <= w_next_lock;
    end
  end

  // Registered output stage: load on accept, drain when consumed, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_src   <= '0;
    end else if (w_accept) begin
      r_out_data  <= w_sel_data;
      r_out_valid <= 1'b1;
      r_out_last  <= w_sel_last;
      r_out_src   <= w_grant;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed scenario bench for stream_mux_rr with
// NUM_IN=4 and a 3-bit select so an out-of-range force index is reachable.
module tb_stream_mux_rr;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 3;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_last;
  logic [NUM_IN-1:0]       in_ready;
  logic                    force_en;
  logic [SEL_W-1:0]        force_sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_last;
  logic [SEL_W-1:0]        out_src;
  logic                    out_ready;

  int checks   = 0;
  int failures = 0;

  stream_mux_rr #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .force_en(force_en),
    .force_sel(force_sel), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_src(out_src), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setCh(input int ch, input logic v, input logic l, input logic [31:0] d);
    in_valid[ch] = v;
    in_last[ch]  = l;
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  task automatic applyReset();
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    force_en  = 1'b0;
    force_sel = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    applyReset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags valid=%b last=%b required 0 0", out_valid, out_last);
    end
    checks++;
    if (out_data !== 32'h0 || out_src !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_data data=%h src=%0d required 0 0", out_data, out_src);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%b required 0000", in_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] expSrc [5];
    expSrc = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    applyReset();
    for (int i = 0; i < NUM_IN; i++) setCh(i, 1'b1, 1'b1, 32'h10 + i);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL rr_first_ready got=%b required 0001", in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== expSrc[k] || out_data !== 32'h10 + 32'(expSrc[k])) begin
        failures++;
        $display("[TB] FAIL rr_beat%0d valid=%b src=%0d data=%h required 1 %0d %h",
                 k, out_valid, out_src, out_data, expSrc[k], 32'h10 + 32'(expSrc[k]));
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [31:0] pkt [3];
    pkt = '{32'hA1, 32'hA2, 32'hA3};
    applyReset();
    setCh(2, 1'b1, 1'b1, 32'hB2);
    for (int k = 0; k < 3; k++) begin
      setCh(1, 1'b1, (k == 2), pkt[k]);
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
        failures++;
        $display("[TB] FAIL lock_ready%0d got=%b required 0010", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 3'd1 || out_data !== pkt[k] || out_last !== (k == 2)) begin
        failures++;
        $display("[TB] FAIL lock_beat%0d valid=%b src=%0d data=%h last=%b required 1 1 %h %b",
                 k, out_valid, out_src, out_data, out_last, pkt[k], (k == 2));
      end
    end
    setCh(1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL lock_after_ready got=%b required 0100", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd2 || out_data !== 32'hB2) begin
      failures++;
      $display("[TB] FAIL lock_next_pkt valid=%b src=%0d data=%h required 1 2 000000b2",
               out_valid, out_src, out_data);
    end
    setCh(2, 1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lock_drain valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    applyReset();
    setCh(0, 1'b1, 1'b1, 32'h55);
    tick();
    out_ready = 1'b0;
    setCh(0, 1'b1, 1'b1, 32'h66);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL bp_ready%0d got=%b required 0000", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h55) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d valid=%b data=%h required 1 00000055", k, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL bp_release_ready got=%b required 0001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h66) begin
      failures++;
      $display("[TB] FAIL bp_next valid=%b data=%h required 1 00000066", out_valid, out_data);
    end
    setCh(0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_drain valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_force();
    applyReset();
    force_en  = 1'b1;
    force_sel = 3'd3;
    setCh(0, 1'b1, 1'b1, 32'h30);
    setCh(3, 1'b1, 1'b1, 32'h33);
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL force_ready got=%b required 1000", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 3'd3 || out_data !== 32'h33) begin
        failures++;
        $display("[TB] FAIL force_beat%0d valid=%b src=%0d data=%h required 1 3 00000033",
                 k, out_valid, out_src, out_data);
      end
    end
    force_sel = 3'd5;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL force_oor_ready got=%b required 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL force_oor_drain valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_force_during_packet();
    logic [31:0] pkt [4];
    pkt = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
    applyReset();
    force_en  = 1'b1;
    force_sel = 3'd2;
    setCh(0, 1'b1, 1'b1, 32'h30);
    for (int k = 0; k < 4; k++) begin
      setCh(2, 1'b1, (k == 3), pkt[k]);
      if (k == 1) force_sel = 3'd0;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
        failures++;
        $display("[TB] FAIL fpkt_ready%0d got=%b required 0100", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 3'd2 || out_data !== pkt[k]) begin
        failures++;
        $display("[TB] FAIL fpkt_beat%0d valid=%b src=%0d data=%h required 1 2 %h",
                 k, out_valid, out_src, out_data, pkt[k]);
      end
    end
    setCh(2, 1'b1, 1'b1, 32'hC5);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL fpkt_switch_ready got=%b required 0001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 32'h30) begin
      failures++;
      $display("[TB] FAIL fpkt_switch valid=%b src=%0d data=%h required 1 0 00000030",
               out_valid, out_src, out_data);
    end
  endtask

  task automatic test_async_reset();
    applyReset();
    setCh(1, 1'b1, 1'b0, 32'hD1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hD1) begin
      failures++;
      $display("[TB] FAIL arst_pre valid=%b data=%h required 1 000000d1", out_valid, out_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 3'd0) begin
      failures++;
      $display("[TB] FAIL arst_now valid=%b data=%h src=%0d required 0 0 0",
               out_valid, out_data, out_src);
    end
    setCh(0, 1'b1, 1'b1, 32'h30);
    setCh(1, 1'b1, 1'b1, 32'hD2);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL arst_restart_ready got=%b required 0001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 32'h30) begin
      failures++;
      $display("[TB] FAIL arst_restart valid=%b src=%0d data=%h required 1 0 00000030",
               out_valid, out_src, out_data);
    end
  endtask

  // Run each scenario in turn, then report the totals.
  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    force_en  = 1'b0;
    force_sel = '0;
    out_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_force();
    test_force_during_packet();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
